spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
//
// Frame-level SPI master controller. It sequences one DW-bit frame:
// chip-select setup delay, bit transfer driven by SCK edge strobes from an
// external clock generator, chip-select hold delay, then a one-cycle done.
//
// Ports
//   sysclk, rst_n        system clock (rising edge), async active-low reset
//   enable               low forces IDLE and idle output values
//   cfg_cpol/cpha/lsb    SPI mode and bit order, latched when start is accepted
//   cfg_div              setup/hold delay and clock-generator divider, latched
//   start, tx_data       frame request and frame payload
//   busy, done, rx_data  status, one-cycle completion pulse, received frame
//   cg_go, cg_last_clk,
//   cg_cpol, cg_divider  controls to the SPI clock generator
//   cg_pos_edge/neg_edge SCK edge strobes from the clock generator
//   cs_n, mosi, miso     SPI pins
// -----------------------------------------------------------------------------
module spi_xfer_ctrl #(
   parameter int N  = 8,
   parameter int DW = 8
) (
   input  logic          sysclk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          cfg_cpol,
   input  logic          cfg_cpha,
   input  logic          cfg_lsb_first,
   input  logic [N-1:0]  cfg_div,
   input  logic          start,
   input  logic [DW-1:0] tx_data,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] rx_data,
   output logic          cg_go,
   output logic          cg_last_clk,
   output logic          cg_cpol,
   output logic [N-1:0]  cg_divider,
   input  logic          cg_pos_edge,
   input  logic          cg_neg_edge,
   output logic          cs_n,
   output logic          mosi,
   input  logic          miso
);

   localparam int CW = $clog2(DW + 1);
   localparam logic [CW-1:0] DW_C = CW'(DW);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

   state_t        state_q;
   logic          cpol_q, cpha_q, lsb_q;
   logic [N-1:0]  div_q;
   logic [N-1:0]  dly_q;
   logic [DW-1:0] tx_q, rx_q, rx_data_q;
   logic [CW-1:0] cnt_q;
   logic          first_q;   // cpha=1: the next shift edge re-presents bit 0
   logic          busy_q, done_q, cs_n_q, mosi_q, go_q, last_q;

   // Edge processing for one cycle. Both strobes may arrive together; the
   // leading edge is applied first and the trailing edge sees its result.
   logic          lead_ev, trail_ev;
   logic [DW-1:0] tx_d, rx_d;
   logic [CW-1:0] cnt_d;
   logic          first_d, fin_d;

   assign lead_ev  = cpol_q ? cg_neg_edge : cg_pos_edge;
   assign trail_ev = cpol_q ? cg_pos_edge : cg_neg_edge;

   always_comb begin
      tx_d    = tx_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      fin_d   = 1'b0;
      if (lead_ev) begin
         if (!cpha_q) begin
            // sample on leading edge; the counter never wraps inside a frame
            if (cnt_d != DW_C) begin
               rx_d  = lsb_q ? {miso, rx_d[DW-1:1]} : {rx_d[DW-2:0], miso};
               cnt_d = cnt_d + CW'(1);
            end
         end else begin
            if (first_d) begin
               first_d = 1'b0;
            end else begin
               tx_d = lsb_q ? (tx_d >> 1) : (tx_d << 1);
            end
         end
      end
      if (trail_ev) begin
         if (cpha_q) begin
            if (cnt_d != DW_C) begin
               rx_d  = lsb_q ? {miso, rx_d[DW-1:1]} : {rx_d[DW-2:0], miso};
               cnt_d = cnt_d + CW'(1);
            end
            if (cnt_d == DW_C) begin
               fin_d = 1'b1;
            end
         end else begin
            // cpha=0: the trailing edge after the last sample closes the frame
            if (cnt_d == DW_C) begin
               fin_d = 1'b1;
            end else begin
               tx_d = lsb_q ? (tx_d >> 1) : (tx_d << 1);
            end
         end
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         div_q     <= '1;
         dly_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         go_q      <= 1'b0;
         last_q    <= 1'b0;
      end else if (!enable) begin
         // abort: idle outputs, no done, received data left untouched
         state_q <= IDLE;
         dly_q   <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         go_q    <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  cpol_q  <= cfg_cpol;
                  cpha_q  <= cfg_cpha;
                  lsb_q   <= cfg_lsb_first;
                  div_q   <= cfg_div;
                  dly_q   <= cfg_div;
                  tx_q    <= tx_data;
                  rx_q    <= '0;
                  cnt_q   <= '0;
                  first_q <= cfg_cpha;
                  busy_q  <= 1'b1;
                  cs_n_q  <= 1'b0;
                  mosi_q  <= cfg_lsb_first ? tx_data[0] : tx_data[DW-1];
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (dly_q == '0) begin
                  go_q    <= 1'b1;
                  state_q <= XFER;
               end else begin
                  dly_q <= dly_q - N'(1);
               end
            end
            XFER: begin
               tx_q    <= tx_d;
               rx_q    <= rx_d;
               cnt_q   <= cnt_d;
               first_q <= first_d;
               mosi_q  <= lsb_q ? tx_d[0] : tx_d[DW-1];
               last_q  <= (cnt_d == DW_C - CW'(1));
               if (fin_d) begin
                  go_q    <= 1'b0;
                  dly_q   <= div_q;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (dly_q == '0) begin
                  cs_n_q    <= 1'b1;
                  done_q    <= 1'b1;
                  rx_data_q <= rx_q;
                  state_q   <= DONE;
               end else begin
                  dly_q <= dly_q - N'(1);
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               mosi_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign rx_data     = rx_data_q;
   assign cg_go       = go_q;
   assign cg_last_clk = last_q;
   assign cs_n        = cs_n_q;
   assign mosi        = mosi_q;

   // In IDLE the generator follows the live configuration so SCK parks at the
   // right level before a frame; reset and disable force the idle values.
   assign cg_cpol    = !rst_n ? 1'b0 :
                       (state_q == IDLE) ? (enable & cfg_cpol) : cpol_q;
   assign cg_divider = !rst_n ? '1 :
                       (state_q == IDLE) ? (enable ? cfg_div : '1) : div_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;
   localparam int N  = 8;
   localparam int DW = 8;

   logic          sysclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          cfg_cpol = 1'b0;
   logic          cfg_cpha = 1'b0;
   logic          cfg_lsb_first = 1'b0;
   logic [N-1:0]  cfg_div = '0;
   logic          start = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          busy, done, cg_go, cg_last_clk, cg_cpol, cs_n, mosi, miso;
   logic [DW-1:0] rx_data;
   logic [N-1:0]  cg_divider;
   logic          cg_pos_edge = 1'b0;
   logic          cg_neg_edge = 1'b0;

   int checks = 0;
   int failures = 0;

   // frame context shared with the clock-generator model
   logic f_cpol = 1'b0;
   logic f_cpha = 1'b0;
   logic dual = 1'b0;
   int   miso_mode = 0;   // 0: loop mosi back, 1: constant 1

   // clock-generator model state and captured mosi at each sample edge
   int          gc = 0;
   logic        lvl = 1'b0;
   logic        is_lead;
   logic [31:0] seen = '0;
   int          seen_n = 0;

   always #5 sysclk = ~sysclk;

   assign miso = (miso_mode == 0) ? mosi : 1'b1;

   spi_xfer_ctrl #(.N(N), .DW(DW)) dut (
      .sysclk        (sysclk),
      .rst_n         (rst_n),
      .enable        (enable),
      .cfg_cpol      (cfg_cpol),
      .cfg_cpha      (cfg_cpha),
      .cfg_lsb_first (cfg_lsb_first),
      .cfg_div       (cfg_div),
      .start         (start),
      .tx_data       (tx_data),
      .busy          (busy),
      .done          (done),
      .rx_data       (rx_data),
      .cg_go         (cg_go),
      .cg_last_clk   (cg_last_clk),
      .cg_cpol       (cg_cpol),
      .cg_divider    (cg_divider),
      .cg_pos_edge   (cg_pos_edge),
      .cg_neg_edge   (cg_neg_edge),
      .cs_n          (cs_n),
      .mosi          (mosi),
      .miso          (miso)
   );

   // SCK generator model: one strobe every divider+1 cycles while cg_go,
   // alternating, first strobe away from the idle level. dual=1 gives both
   // strobes every cycle.
   always @(negedge sysclk) begin
      if (!busy && cs_n) seen_n = 0;
      if (!cg_go) begin
         gc = 0;
         lvl = cg_cpol;
         cg_pos_edge = 1'b0;
         cg_neg_edge = 1'b0;
      end else if (dual) begin
         cg_pos_edge = 1'b1;
         cg_neg_edge = 1'b1;
         if (!f_cpha) begin
            if (seen_n < 32) seen[seen_n[4:0]] = mosi;
            seen_n++;
         end
      end else if (gc == int'(cg_divider)) begin
         gc = 0;
         cg_pos_edge = !lvl;
         cg_neg_edge = lvl;
         lvl = !lvl;
         is_lead = (cg_pos_edge != f_cpol);
         if (is_lead != f_cpha) begin
            if (seen_n < 32) seen[seen_n[4:0]] = mosi;
            seen_n++;
         end
      end else begin
         gc++;
         cg_pos_edge = 1'b0;
         cg_neg_edge = 1'b0;
      end
   end

   task automatic run_frame(input string name, input logic cpol, input logic cpha,
                            input logic lsb, input logic [7:0] div, input logic [7:0] tx,
                            input int mmode, input logic dl, input logic [7:0] exp_rx);
      int cyc, csl, lastc, donec, exp_csl, exp_last;
      logic [7:0] w;
      f_cpol = cpol; f_cpha = cpha; dual = dl; miso_mode = mmode;
      @(negedge sysclk);
      cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cfg_div = div;
      tx_data = tx; start = 1'b1;
      @(negedge sysclk);
      start = 1'b0;
      cfg_cpol = ~cpol; cfg_cpha = ~cpha; cfg_lsb_first = ~lsb; cfg_div = ~div; tx_data = ~tx;
      #1;
      checks++;
      if (cg_cpol !== cpol || cg_divider !== div) begin
         failures++;
         $display("FAIL %s_latched: got cpol=%b div=%h expected cpol=%b div=%h",
                  name, cg_cpol, cg_divider, cpol, div);
      end
      cyc = 0; csl = 0; lastc = 0; donec = 0;
      while (cyc < 400 && donec == 0) begin
         if (!cs_n) csl++;
         if (cg_last_clk) lastc++;
         if (done) begin
            donec++;
            checks++;
            if (rx_data !== exp_rx) begin
               failures++;
               $display("FAIL %s_rx: got %h expected %h", name, rx_data, exp_rx);
            end
         end
         if (donec == 0) begin
            @(negedge sysclk);
            cyc++;
         end
      end
      checks++;
      if (donec != 1) begin
         failures++;
         $display("FAIL %s_done: got %0d done pulses within 400 cycles expected 1", name, donec);
      end
      exp_csl  = dl ? (2 * (int'(div) + 1) + DW) : 18 * (int'(div) + 1);
      exp_last = dl ? 1 : 2 * (int'(div) + 1);
      checks++;
      if (csl != exp_csl) begin
         failures++;
         $display("FAIL %s_csn_low: got %0d cycles expected %0d", name, csl, exp_csl);
      end
      checks++;
      if (lastc != exp_last) begin
         failures++;
         $display("FAIL %s_last_clk: got %0d cycles expected %0d", name, lastc, exp_last);
      end
      w = '0;
      for (int i = 0; i < DW; i++) w[lsb ? i : DW - 1 - i] = seen[i];
      checks++;
      if (seen_n != DW || w !== tx) begin
         failures++;
         $display("FAIL %s_mosi: got %0d bits word %h expected %0d bits word %h",
                  name, seen_n, w, DW, tx);
      end
      @(negedge sysclk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_after: got done=%b busy=%b expected done=0 busy=0", name, done, busy);
      end
      dual = 1'b0;
      $display("frame %s tx=%h rx=%h cs_n_low=%0d last_clk=%0d", name, tx, rx_data, csl, lastc);
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({busy, done, cs_n, mosi, cg_go, cg_last_clk, cg_cpol} !== 7'b0010000) begin
         failures++;
         $display("FAIL %s_ctrl: got busy,done,cs_n,mosi,go,last,cpol=%b expected 0010000", name,
                  {busy, done, cs_n, mosi, cg_go, cg_last_clk, cg_cpol});
      end
      checks++;
      if (rx_data !== 8'h00) begin
         failures++;
         $display("FAIL %s_rx: got %h expected 00", name, rx_data);
      end
      checks++;
      if (cg_divider !== 8'hFF) begin
         failures++;
         $display("FAIL %s_div: got %h expected ff", name, cg_divider);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; cfg_cpol = 1'b1; cfg_div = 8'h05; start = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(negedge sysclk);
      rst_n = 1'b1;
      @(negedge sysclk);
      checks++;
      if (cg_cpol !== 1'b1 || cg_divider !== 8'h05) begin
         failures++;
         $display("FAIL idle_live: got cpol=%b div=%h expected cpol=1 div=05", cg_cpol, cg_divider);
      end
      enable = 1'b0;
      #1;
      checks++;
      if (cg_cpol !== 1'b0 || cg_divider !== 8'hFF) begin
         failures++;
         $display("FAIL disabled_idle: got cpol=%b div=%h expected cpol=0 div=ff", cg_cpol, cg_divider);
      end
      enable = 1'b1;
      $display("reset checks done");
   endtask

   task automatic test_modes();
      run_frame("mode0", 1'b0, 1'b0, 1'b0, 8'd2, 8'hA5, 0, 1'b0, 8'hA5);
      run_frame("mode1", 1'b0, 1'b1, 1'b0, 8'd1, 8'h96, 0, 1'b0, 8'h96);
      run_frame("mode2", 1'b1, 1'b0, 1'b1, 8'd3, 8'h5B, 0, 1'b0, 8'h5B);
      run_frame("mode3", 1'b1, 1'b1, 1'b1, 8'd2, 8'h3C, 1, 1'b0, 8'hFF);
   endtask

   task automatic test_div0();
      run_frame("div0_m1", 1'b0, 1'b1, 1'b0, 8'd0, 8'h81, 0, 1'b0, 8'h81);
      run_frame("div0_m0", 1'b0, 1'b0, 1'b1, 8'd0, 8'h4D, 0, 1'b0, 8'h4D);
   endtask

   task automatic test_simultaneous();
      run_frame("dual_m0", 1'b0, 1'b0, 1'b0, 8'd0, 8'hE7, 0, 1'b1, 8'hE7);
      run_frame("dual_m2", 1'b1, 1'b0, 1'b1, 8'd0, 8'h1D, 0, 1'b1, 8'h1D);
   endtask

   task automatic test_back_to_back();
      int cyc, t1;
      logic seen_busy;
      f_cpol = 1'b0; f_cpha = 1'b1; dual = 1'b0; miso_mode = 0;
      @(negedge sysclk);
      cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_lsb_first = 1'b0; cfg_div = 8'd0;
      tx_data = 8'h5A; start = 1'b1;
      cyc = 0; seen_busy = 1'b0;
      while (cyc < 200 && !done) begin
         @(negedge sysclk);
         cyc++;
         if (busy && !seen_busy) begin
            seen_busy = 1'b1;
            tx_data = 8'hC3;
         end
      end
      t1 = cyc;
      checks++;
      if (done !== 1'b1 || rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL b2b_first: got done=%b rx=%h expected done=1 rx=5a", done, rx_data);
      end
      @(negedge sysclk);
      cyc++;
      checks++;
      if (busy !== 1'b0 || cs_n !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle: got busy=%b cs_n=%b expected busy=0 cs_n=1", busy, cs_n);
      end
      @(negedge sysclk);
      cyc++;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_restart: got busy=%b expected 1", busy);
      end
      start = 1'b0;
      while (cyc < 400 && !done) begin
         @(negedge sysclk);
         cyc++;
      end
      checks++;
      if (done !== 1'b1 || cyc - t1 != 20) begin
         failures++;
         $display("FAIL b2b_spacing: got done=%b spacing=%0d expected done=1 spacing=20", done, cyc - t1);
      end
      checks++;
      if (rx_data !== 8'hC3) begin
         failures++;
         $display("FAIL b2b_second: got rx=%h expected c3", rx_data);
      end
      @(negedge sysclk);
      $display("back_to_back first=5a second=%h spacing=%0d", rx_data, cyc - t1);
   endtask

   task automatic test_enable_drop();
      int cyc, donec;
      f_cpol = 1'b0; f_cpha = 1'b0; dual = 1'b0; miso_mode = 0;
      @(negedge sysclk);
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 8'd2;
      tx_data = 8'h0F; start = 1'b1;
      @(negedge sysclk);
      start = 1'b0;
      cyc = 0;
      while (cyc < 300 && seen_n < 4) begin
         @(negedge sysclk);
         cyc++;
      end
      checks++;
      if (seen_n < 4) begin
         failures++;
         $display("FAIL en_reach_bit4: got %0d bits expected 4", seen_n);
      end
      enable = 1'b0;
      @(negedge sysclk);
      checks++;
      if (cs_n !== 1'b1 || cg_go !== 1'b0 || busy !== 1'b0 || cg_last_clk !== 1'b0) begin
         failures++;
         $display("FAIL en_abort: got cs_n=%b go=%b busy=%b last=%b expected 1 0 0 0",
                  cs_n, cg_go, busy, cg_last_clk);
      end
      donec = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) donec++;
         @(negedge sysclk);
      end
      checks++;
      if (donec != 0 || rx_data !== 8'hC3) begin
         failures++;
         $display("FAIL en_no_done: got done=%0d rx=%h expected done=0 rx=c3", donec, rx_data);
      end
      enable = 1'b1;
      $display("enable_drop rx_kept=%h", rx_data);
   endtask

   task automatic test_reset_mid();
      int cyc;
      f_cpol = 1'b0; f_cpha = 1'b0; dual = 1'b0; miso_mode = 0;
      @(negedge sysclk);
      cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 8'd2;
      f_cpol = 1'b1;
      tx_data = 8'h33; start = 1'b1;
      @(negedge sysclk);
      start = 1'b0;
      cyc = 0;
      while (cyc < 100 && !cg_go) begin
         @(negedge sysclk);
         cyc++;
      end
      checks++;
      if (cg_go !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_xfer: got cg_go=%b expected 1", cg_go);
      end
      repeat (10) @(negedge sysclk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rstmid");
      @(negedge sysclk);
      rst_n = 1'b1;
      $display("reset_mid outputs checked");
      run_frame("after_rst", 1'b0, 1'b0, 1'b0, 8'd1, 8'h6E, 0, 1'b0, 8'h6E);
   endtask

   initial begin
      test_reset();
      test_modes();
      test_div0();
      test_simultaneous();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
